// File: rtl/aes_block_sequencer_if.sv
// rtl/aes_block_sequencer_if.sv - config/block/result/core handshake bundle for aes_block_sequencer (cfg_iv under AES_SEQ_CBC_EN)
interface aes_block_sequencer_if;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [255:0] cfg_key;
    logic         cfg_keylen;
    logic         cfg_encdec;
`ifdef AES_SEQ_CBC_EN
    logic [127:0] cfg_iv;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         core_init;
    logic         core_next;
    logic [255:0] core_key;
    logic         core_keylen;
    logic         core_encdec;
    logic [127:0] core_block;
    logic         core_ready;
    logic         core_result_valid;
    logic [127:0] core_result;
    logic         busy;
    logic         err_timeout;

    // Sequencer side
    modport slave (
`ifdef AES_SEQ_CBC_EN
        input  cfg_iv,
`endif
        input  cfg_valid, cfg_key, cfg_keylen, cfg_encdec,
        input  in_valid, in_block, out_ready,
        input  core_ready, core_result_valid, core_result,
        output cfg_ready, in_ready, out_valid, out_block,
        output core_init, core_next, core_key, core_keylen, core_encdec, core_block,
        output busy, err_timeout
    );

    // Environment side: upstream source, downstream sink and the AES core
    modport master (
`ifdef AES_SEQ_CBC_EN
        output cfg_iv,
`endif
        output cfg_valid, cfg_key, cfg_keylen, cfg_encdec,
        output in_valid, in_block, out_ready,
        output core_ready, core_result_valid, core_result,
        input  cfg_ready, in_ready, out_valid, out_block,
        input  core_init, core_next, core_key, core_keylen, core_encdec, core_block,
        input  busy, err_timeout
    );
endinterface

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - AES core init/next sequencer with watchdog; CBC chaining when AES_SEQ_CBC_EN is defined
module aes_block_sequencer #(
    parameter int WDOG_CYCLES = 64,
    parameter int WDOG_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_block_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_READY  = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [255:0]      key_r;
    logic              keylen_r;
    logic              encdec_r;
    logic [127:0]      blk_r;
    logic [127:0]      out_r;
    logic [127:0]      blk_in;
    logic [127:0]      res_out;
    logic              init_r;
    logic              next_r;
    logic              ov_r;
    logic              err_r;
    logic              key_valid;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_inc;
    logic              cfg_rdy;
    logic              in_rdy;
    logic              cfg_acc;
    logic              in_acc;
    logic              out_acc;
    logic              key_done;
    logic              res_cap;
    logic              watched;
    logic              wdog_fire;

    // Handshake decode; ready outputs are forced low while reset is held
    always_comb begin
        cfg_rdy   = !rst && (state == S_IDLE || state == S_READY);
        in_rdy    = !rst && (state == S_READY) && key_valid && !bus.cfg_valid;
        cfg_acc   = cfg_rdy && bus.cfg_valid;
        in_acc    = in_rdy && bus.in_valid;
        out_acc   = ov_r && bus.out_ready;
        // core_ready is stale during the init pulse cycle, so it only counts afterwards
        key_done  = (state == S_KEYEXP) && !init_r && bus.core_ready;
        res_cap   = (state == S_WAIT) && bus.core_result_valid;
        watched   = (state == S_KEYEXP) || (state == S_WAIT);
        wdog_inc  = wdog + WDOG_W'(1);
        wdog_fire = watched && !key_done && !res_cap && (wdog_inc == WDOG_W'(WDOG_CYCLES));
    end

`ifdef AES_SEQ_CBC_EN
    logic [127:0] chain;

    // CBC data path: encrypt whitens the input, decrypt whitens the result
    always_comb begin
        blk_in  = encdec_r ? (bus.in_block ^ chain) : bus.in_block;
        res_out = encdec_r ? bus.core_result : (bus.core_result ^ chain);
    end

    // Chain register: IV on config, then previous ciphertext
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else if (cfg_acc) begin
            chain <= bus.cfg_iv;
        end else if (res_cap) begin
            chain <= encdec_r ? bus.core_result : blk_r;
        end
    end
`else
    // ECB data path: blocks pass straight through
    always_comb begin
        blk_in  = bus.in_block;
        res_out = bus.core_result;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a new config always wins over a waiting block
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cfg_acc) state_nxt = S_KEYEXP;
            S_KEYEXP: begin
                if (key_done)       state_nxt = S_READY;
                else if (wdog_fire) state_nxt = S_IDLE;
            end
            S_READY: begin
                if (cfg_acc)     state_nxt = S_KEYEXP;
                else if (in_acc) state_nxt = S_ISSUE;
            end
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (res_cap)        state_nxt = S_OUT;
                else if (wdog_fire) state_nxt = S_IDLE;
            end
            S_OUT:    if (out_acc) state_nxt = S_READY;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Config/block registers, core pulses, result register, watchdog and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r     <= '0;
            keylen_r  <= 1'b0;
            encdec_r  <= 1'b0;
            blk_r     <= '0;
            out_r     <= '0;
            init_r    <= 1'b0;
            next_r    <= 1'b0;
            ov_r      <= 1'b0;
            err_r     <= 1'b0;
            key_valid <= 1'b0;
            wdog      <= '0;
        end else begin
            init_r <= cfg_acc;
            next_r <= in_acc;
            ov_r   <= (state_nxt == S_OUT);
            if (cfg_acc) begin
                key_r     <= bus.cfg_key;
                keylen_r  <= bus.cfg_keylen;
                encdec_r  <= bus.cfg_encdec;
                err_r     <= 1'b0;
                key_valid <= 1'b0;
            end
            if (key_done) key_valid <= 1'b1;
            if (wdog_fire) begin
                err_r     <= 1'b1;
                key_valid <= 1'b0;
            end
            if (in_acc)  blk_r <= blk_in;
            if (res_cap) out_r <= res_out;
            if (watched && (state_nxt == state)) wdog <= wdog_inc;
            else                                 wdog <= '0;
        end
    end

    assign bus.cfg_ready   = cfg_rdy;
    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = ov_r;
    assign bus.out_block   = out_r;
    assign bus.core_init   = init_r;
    assign bus.core_next   = next_r;
    assign bus.core_key    = key_r;
    assign bus.core_keylen = keylen_r;
    assign bus.core_encdec = encdec_r;
    assign bus.core_block  = blk_r;
    assign bus.busy        = (state != S_IDLE) && (state != S_READY);
    assign bus.err_timeout = err_r;
endmodule
